// File: rtl/handshake_elastic_fifo.sv
// Non-transparent elastic FIFO for a ready/valid channel.
// All handshake outputs come from registers, so the producer's ready path is cut.
module handshake_elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] slots [NUM_SLOTS];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Pointers wrap at NUM_SLOTS, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign ins_ready  = !full;
    assign outs_valid = !empty;
    assign outs       = slots[head];
    assign push       = ins_valid && ins_ready;
    assign pop        = outs_valid && outs_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else if (push) begin
            slots[tail] <= ins;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Directed bench for handshake_elastic_fifo: a 4-slot and a 3-slot instance,
// each checked against a queue of the values the bench pushed.
module tb_handshake_elastic_fifo;

    localparam int W = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] din_a, outs_a, din_b, outs_b;
    logic         iv_a, ir_a, ov_a, ro_a;
    logic         iv_b, ir_b, ov_b, ro_b;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_a     = 0;
    int rx_b     = 0;

    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];

    handshake_elastic_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(4)) dut_a (
        .clk(clk), .rst(rst),
        .ins(din_a), .ins_valid(iv_a), .ins_ready(ir_a),
        .outs(outs_a), .outs_valid(ov_a), .outs_ready(ro_a)
    );

    handshake_elastic_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(3)) dut_b (
        .clk(clk), .rst(rst),
        .ins(din_b), .ins_valid(iv_b), .ins_ready(ir_b),
        .outs(outs_b), .outs_valid(ov_b), .outs_ready(ro_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: handshakes are sampled mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ov_a && ro_a) begin
                check("a_pop_expected", 64'(q_a.size() != 0), 64'd1);
                if (q_a.size() != 0) begin
                    check("a_data", 64'(outs_a), 64'(q_a.pop_front()));
                    rx_a++;
                end
            end
            if (iv_a && ir_a) q_a.push_back(din_a);
            if (ov_b && ro_b) begin
                check("b_pop_expected", 64'(q_b.size() != 0), 64'd1);
                if (q_b.size() != 0) begin
                    check("b_data", 64'(outs_b), 64'(q_b.pop_front()));
                    rx_b++;
                end
            end
            if (iv_b && ir_b) q_b.push_back(din_b);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, finish required");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] lat_vals [3];
        logic         acc;
        int           next;
        int           pushed;
        int           rx0;

        lat_vals[0] = 36'h709054E73;
        lat_vals[1] = 36'h000000001;
        lat_vals[2] = 36'hFFFFFFFFF;

        rst  = 1'b1;
        iv_a = 1'b0; ro_a = 1'b0; din_a = '0;
        iv_b = 1'b0; ro_b = 1'b0; din_b = '0;
        #2 rst = 1'b0;
        #1;
        check("por_valid", 64'(ov_a), 64'd0);
        check("por_ready", 64'(ir_a), 64'd1);
        check("por_outs",  64'(outs_a), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle();

        // Load an entry, then assert reset mid-cycle with no edge.
        din_a = 36'h123; iv_a = 1'b1;
        cycle();
        iv_a = 1'b0;
        check("pre_rst_outs", 64'(outs_a), 64'h123);
        #2 rst = 1'b0;
        q_a.delete();
        #1;
        check("rst_valid", 64'(ov_a), 64'd0);
        check("rst_ready", 64'(ir_a), 64'd1);
        check("rst_outs",  64'(outs_a), 64'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        cycle();

        // Single push into empty FIFO: never forwarded in the same cycle.
        din_a = lat_vals[0]; iv_a = 1'b1;
        @(negedge clk);
        check("no_forward", 64'(ov_a), 64'd0);
        cycle();
        iv_a = 1'b0;
        check("first_valid", 64'(ov_a), 64'd1);
        check("first_data",  64'(outs_a), 64'(lat_vals[0]));
        check("first_slot0", 64'(dut_a.slots[0]), 64'(lat_vals[0]));
        ro_a = 1'b1;
        cycle();
        ro_a = 1'b0;
        check("empty_after_pop", 64'(ov_a), 64'd0);

        // Back-to-back pushes with a ready consumer: one-cycle latency, no bubbles.
        ro_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_a = lat_vals[i]; iv_a = 1'b1;
            cycle();
            check("lat_valid", 64'(ov_a), 64'd1);
            check("lat_data",  64'(outs_a), 64'(lat_vals[i]));
        end
        iv_a = 1'b0;
        cycle();
        check("lat_drained", 64'(ov_a), 64'd0);
        ro_a = 1'b0;

        // Fill and backpressure: values 5 and 6 must wait upstream.
        next = 1;
        for (int c = 0; c < 6; c++) begin
            din_a = W'(next); iv_a = 1'b1;
            @(negedge clk);
            check("fill_ready", 64'(ir_a), 64'(c < 4));
            acc = ir_a;
            cycle();
            if (acc) next++;
        end
        check("fill_accepted", 64'(next), 64'd5);
        ro_a = 1'b1;
        @(negedge clk);
        check("full_pop_ready", 64'(ir_a), 64'd0);
        cycle();
        check("ready_after_pop", 64'(ir_a), 64'd1);
        for (int c = 0; c < 20 && next <= 6; c++) begin
            din_a = W'(next); iv_a = 1'b1;
            @(negedge clk);
            acc = ir_a;
            cycle();
            if (acc) next++;
        end
        iv_a = 1'b0;
        for (int c = 0; c < 20 && q_a.size() != 0; c++) cycle();
        check("fill_drained", 64'(q_a.size()), 64'd0);
        check("fill_empty", 64'(ov_a), 64'd0);
        ro_a = 1'b0;

        // Simultaneous push and pop at occupancy 2.
        din_a = 36'hB0; iv_a = 1'b1;
        cycle();
        din_a = 36'hB1;
        cycle();
        check("sim_start_count", 64'(dut_a.count), 64'd2);
        ro_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din_a = W'(36'hC0 + i);
            cycle();
            check("sim_count", 64'(dut_a.count), 64'd2);
            check("sim_ready", 64'(ir_a), 64'd1);
            check("sim_valid", 64'(ov_a), 64'd1);
        end
        iv_a = 1'b0;
        cycle();
        cycle();
        check("sim_empty", 64'(ov_a), 64'd0);
        check("sim_q_empty", 64'(q_a.size()), 64'd0);
        ro_a = 1'b0;

        // Wrap-around on the 3-slot instance with random backpressure.
        pushed = 0;
        for (int c = 0; c < 300 && rx_b < 10; c++) begin
            ro_b = 1'($urandom_range(0, 1));
            if (pushed < 10) begin
                din_b = W'(36'hA0 + pushed); iv_b = 1'b1;
            end else begin
                iv_b = 1'b0;
            end
            @(negedge clk);
            acc = iv_b && ir_b;
            check("b_ptr_range", 64'(dut_b.head < 3 && dut_b.tail < 3), 64'd1);
            cycle();
            if (acc) pushed++;
        end
        iv_b = 1'b0; ro_b = 1'b0;
        check("b_rx_count", 64'(rx_b), 64'd10);
        check("b_tail_wrap", 64'(dut_b.tail), 64'd1);
        check("b_head_wrap", 64'(dut_b.head), 64'd1);

        // Reset with three entries stored discards them all.
        for (int i = 1; i <= 3; i++) begin
            din_a = W'(i); iv_a = 1'b1;
            cycle();
        end
        iv_a = 1'b0;
        check("pre_rst2_valid", 64'(ov_a), 64'd1);
        #2 rst = 1'b0;
        q_a.delete();
        #1;
        check("rst2_valid", 64'(ov_a), 64'd0);
        check("rst2_ready", 64'(ir_a), 64'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        cycle();
        rx0 = rx_a;
        din_a = 36'h5; iv_a = 1'b1; ro_a = 1'b1;
        cycle();
        iv_a = 1'b0;
        check("rst2_first_out", 64'(outs_a), 64'h5);
        cycle();
        cycle();
        check("rst2_rx", 64'(rx_a - rx0), 64'd1);
        check("rst2_empty", 64'(ov_a), 64'd0);
        ro_a = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
